// File: rtl/temporal_aligner_n.sv
// Multi-channel timestamp aligner: on a sync request, collects per-channel samples around a
// target time and emits one frame holding the nearest or previous sample of every channel.
module temporal_aligner_n #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned TS_W      = 64,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned MAX_SKEW  = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sync_signal,
  input  logic [TS_W-1:0]             t_common,
  input  logic                        mode,
  input  logic [NUM_CH-1:0]           ch_valid,
  output logic [NUM_CH-1:0]           ch_ready,
  input  logic [NUM_CH*TS_W-1:0]      ch_ts,
  input  logic [NUM_CH*PAYLOAD_W-1:0] ch_data,
  output logic [NUM_CH*PAYLOAD_W-1:0] fused_data,
  output logic [TS_W-1:0]             fused_ts,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH-1:0]           err_ch,
  output logic                        error,
  output logic                        sync_drop
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [TS_W:0]   SkewMax = (TS_W + 1)'(MAX_SKEW);

  typedef enum logic [1:0] {StIdle, StCollect, StOutput} state_e;

  state_e                state_q;
  logic [TS_W-1:0]       target_q;
  logic                  mode_q;
  logic [CntW-1:0]       cnt_q;
  logic [NUM_CH-1:0]     lock_q, lock_d;
  logic [NUM_CH-1:0]     prev_v_q, prev_v_d, next_v_q, next_v_d;
  logic [TS_W-1:0]       prev_ts_q [NUM_CH];
  logic [TS_W-1:0]       prev_ts_d [NUM_CH];
  logic [TS_W-1:0]       next_ts_q [NUM_CH];
  logic [TS_W-1:0]       next_ts_d [NUM_CH];
  logic [PAYLOAD_W-1:0]  prev_data_q [NUM_CH];
  logic [PAYLOAD_W-1:0]  prev_data_d [NUM_CH];
  logic [PAYLOAD_W-1:0]  next_data_q [NUM_CH];
  logic [PAYLOAD_W-1:0]  next_data_d [NUM_CH];
  logic [NUM_CH*PAYLOAD_W-1:0] sel_data;
  logic [NUM_CH-1:0]           sel_err;

  // One extra bit keeps the difference exact for any pair of unsigned timestamps.
  function automatic logic [TS_W:0] abs_diff(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  assign ch_ready = (state_q == StCollect) ? ~lock_q : '0;
  assign error    = out_valid & (|err_ch);

  // Slot next-state: carry-over when a frame starts, sample capture while collecting.
  always_comb begin
    lock_d      = lock_q;
    prev_v_d    = prev_v_q;
    next_v_d    = next_v_q;
    prev_ts_d   = prev_ts_q;
    next_ts_d   = next_ts_q;
    prev_data_d = prev_data_q;
    next_data_d = next_data_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == StIdle && sync_signal) begin
        lock_d[i] = 1'b0;
        if (next_v_q[i]) begin
          if (next_ts_q[i] <= t_common) begin
            prev_v_d[i]    = 1'b1;
            prev_ts_d[i]   = next_ts_q[i];
            prev_data_d[i] = next_data_q[i];
            next_v_d[i]    = 1'b0;
          end else begin
            lock_d[i] = 1'b1;
          end
        end
      end else if (ch_valid[i] && ch_ready[i]) begin
        if (!(prev_v_q[i] && (ch_ts[i*TS_W +: TS_W] < prev_ts_q[i]))) begin
          if (ch_ts[i*TS_W +: TS_W] <= target_q) begin
            prev_v_d[i]    = 1'b1;
            prev_ts_d[i]   = ch_ts[i*TS_W +: TS_W];
            prev_data_d[i] = ch_data[i*PAYLOAD_W +: PAYLOAD_W];
          end else begin
            next_v_d[i]    = 1'b1;
            next_ts_d[i]   = ch_ts[i*TS_W +: TS_W];
            next_data_d[i] = ch_data[i*PAYLOAD_W +: PAYLOAD_W];
            lock_d[i]      = 1'b1;
          end
        end
      end
    end
  end

  // Per-lane selection; an unlocked lane (timeout) or a hold with no PREV emits zero.
  always_comb begin
    logic            use_prev;
    logic [TS_W-1:0] chosen_ts;
    sel_data = '0;
    sel_err  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      use_prev  = 1'b0;
      chosen_ts = '0;
      if (!lock_d[i]) begin
        sel_err[i] = 1'b1;
      end else if (mode_q && !prev_v_d[i]) begin
        sel_err[i] = 1'b1;
      end else begin
        use_prev = mode_q ? 1'b1 : (prev_v_d[i] &&
                   (abs_diff(target_q, prev_ts_d[i]) <= abs_diff(next_ts_d[i], target_q)));
        chosen_ts = use_prev ? prev_ts_d[i] : next_ts_d[i];
        sel_data[i*PAYLOAD_W +: PAYLOAD_W] = use_prev ? prev_data_d[i] : next_data_d[i];
        sel_err[i] = abs_diff(chosen_ts, target_q) > SkewMax;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      target_q   <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      lock_q     <= '0;
      prev_v_q   <= '0;
      next_v_q   <= '0;
      out_valid  <= 1'b0;
      fused_data <= '0;
      fused_ts   <= '0;
      err_ch     <= '0;
      sync_drop  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        prev_ts_q[i]   <= '0;
        next_ts_q[i]   <= '0;
        prev_data_q[i] <= '0;
        next_data_q[i] <= '0;
      end
    end else begin
      sync_drop   <= sync_signal && (state_q != StIdle);
      lock_q      <= lock_d;
      prev_v_q    <= prev_v_d;
      next_v_q    <= next_v_d;
      prev_ts_q   <= prev_ts_d;
      next_ts_q   <= next_ts_d;
      prev_data_q <= prev_data_d;
      next_data_q <= next_data_d;
      unique case (state_q)
        StIdle: begin
          if (sync_signal) begin
            state_q  <= StCollect;
            target_q <= t_common;
            mode_q   <= mode;
            cnt_q    <= '0;
          end
        end
        StCollect: begin
          cnt_q <= cnt_q + 1'b1;
          if ((&lock_q) || (cnt_q == CntLast)) begin
            state_q    <= StOutput;
            out_valid  <= 1'b1;
            fused_data <= sel_data;
            fused_ts   <= target_q;
            err_ch     <= sel_err;
          end
        end
        StOutput: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_temporal_aligner_n.sv
// Randomised bench for temporal_aligner_n: a timestamp-level model predicts each frame into a
// scoreboard queue, and an independent monitor checks every frame the DUT hands over.
module tb_temporal_aligner_n;

  localparam int NCH  = 2;
  localparam int PW   = 32;
  localparam int TW   = 32;
  localparam int TO   = 16;
  localparam int SKEW = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              sync_signal = 1'b0;
  logic [TW-1:0]     t_common = '0;
  logic              mode = 1'b0;
  logic              out_ready = 1'b0;
  logic [NCH-1:0]    ch_valid, ch_ready, err_ch;
  logic [NCH*TW-1:0] ch_ts;
  logic [NCH*PW-1:0] ch_data, fused_data;
  logic [TW-1:0]     fused_ts;
  logic              out_valid, error, sync_drop;

  logic          drv_valid [NCH];
  logic [TW-1:0] drv_ts    [NCH];
  logic [PW-1:0] drv_data  [NCH];

  assign ch_valid = {drv_valid[1], drv_valid[0]};
  assign ch_ts    = {drv_ts[1], drv_ts[0]};
  assign ch_data  = {drv_data[1], drv_data[0]};

  temporal_aligner_n #(
    .NUM_CH(NCH), .PAYLOAD_W(PW), .TS_W(TW), .TIMEOUT(TO), .MAX_SKEW(SKEW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_signal(sync_signal), .t_common(t_common), .mode(mode),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_ts(ch_ts), .ch_data(ch_data),
    .fused_data(fused_data), .fused_ts(fused_ts), .out_valid(out_valid),
    .out_ready(out_ready), .err_ch(err_ch), .error(error), .sync_drop(sync_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NCH*PW-1:0] data;
    logic [TW-1:0]     ts;
    logic [NCH-1:0]    err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Model: what each channel currently remembers about the latest samples at/after a target.
  bit            m_pv [NCH], m_nv [NCH], m_lock [NCH];
  longint        m_pts [NCH], m_nts [NCH];
  logic [PW-1:0] m_pd [NCH], m_nd [NCH];

  // Stimulus samples for the next frame.
  longint        s_ts  [NCH][8];
  logic [PW-1:0] s_dat [NCH][8];
  int            s_n   [NCH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint absd(input longint a, input longint b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pv[c] = 0; m_nv[c] = 0; m_lock[c] = 0;
      m_pts[c] = 0; m_nts[c] = 0; m_pd[c] = '0; m_nd[c] = '0;
    end
  endtask

  task automatic clear_s();
    for (int c = 0; c < NCH; c++) s_n[c] = 0;
  endtask

  task automatic add_s(input int c, input longint ts);
    s_ts[c][s_n[c]]  = ts;
    s_dat[c][s_n[c]] = $urandom;
    s_n[c]++;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ch_ready"},   64'(ch_ready),   64'd0);
    chk({tag, "_out_valid"},  64'(out_valid),  64'd0);
    chk({tag, "_fused_data"}, 64'(fused_data), 64'd0);
    chk({tag, "_fused_ts"},   64'(fused_ts),   64'd0);
    chk({tag, "_err_ch"},     64'(err_ch),     64'd0);
    chk({tag, "_error"},      64'(error),      64'd0);
    chk({tag, "_sync_drop"},  64'(sync_drop),  64'd0);
  endtask

  task automatic do_reset();
    for (int c = 0; c < NCH; c++) drv_valid[c] = 1'b0;
    sync_signal = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_reset_outs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ch(input int c);
    for (int k = 0; k < s_n[c]; k++) begin
      int n;
      n = 0;
      drv_valid[c] = 1'b1;
      drv_ts[c]    = TW'(s_ts[c][k]);
      drv_data[c]  = s_dat[c][k];
      do begin
        @(negedge clk);
        n++;
      end while (!ch_ready[c] && n < 30);
      checks++;
      if (!ch_ready[c]) begin
        errors++;
        $display("FAIL sample_accept ch%0d actual ready=0 required ready=1", c);
        break;
      end
      @(posedge clk);
      #1;
    end
    drv_valid[c] = 1'b0;
  endtask

  // Predicts one frame, issues the sync, feeds samples and handles the output handshake.
  task automatic run_frame(input longint tgt, input logic md, input int hold, input bit poke,
                           input int exp_lat);
    exp_t   e;
    bit     usep;
    longint cts;
    int     n;
    int     sync_cyc;
    for (int c = 0; c < NCH; c++) begin
      m_lock[c] = 0;
      if (m_nv[c]) begin
        if (m_nts[c] <= tgt) begin
          m_pv[c] = 1; m_pts[c] = m_nts[c]; m_pd[c] = m_nd[c]; m_nv[c] = 0;
        end else begin
          m_lock[c] = 1;
        end
      end
      if (m_lock[c]) s_n[c] = 0;
      for (int k = 0; k < s_n[c]; k++) begin
        if (!(m_pv[c] && s_ts[c][k] < m_pts[c])) begin
          if (s_ts[c][k] <= tgt) begin
            m_pv[c] = 1; m_pts[c] = s_ts[c][k]; m_pd[c] = s_dat[c][k];
          end else begin
            m_nv[c] = 1; m_nts[c] = s_ts[c][k]; m_nd[c] = s_dat[c][k]; m_lock[c] = 1;
          end
        end
      end
    end
    e.data = '0;
    e.err  = '0;
    e.ts   = TW'(tgt);
    for (int c = 0; c < NCH; c++) begin
      if (!m_lock[c] || (md && !m_pv[c])) begin
        e.err[c] = 1'b1;
      end else begin
        usep = md ? 1'b1 : (m_pv[c] && absd(tgt, m_pts[c]) <= absd(m_nts[c], tgt));
        cts  = usep ? m_pts[c] : m_nts[c];
        e.data[c*PW +: PW] = usep ? m_pd[c] : m_nd[c];
        if (absd(cts, tgt) > SKEW) e.err[c] = 1'b1;
      end
    end
    exp_q.push_back(e);

    sync_signal = 1'b1;
    t_common    = TW'(tgt);
    mode        = md;
    @(posedge clk);
    #1;
    sync_signal = 1'b0;
    sync_cyc    = cyc;
    fork
      drive_ch(0);
      drive_ch(1);
    join

    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL frame_arrival actual out_valid=0 required out_valid=1 target=%0d", tgt);
      void'(exp_q.pop_front());
      return;
    end
    if (exp_lat > 0) chk("timeout_latency", 64'(cyc - sync_cyc), 64'(exp_lat));

    @(posedge clk);
    #1;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) sync_signal = 1'b1;
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      if (exp_q.size() > 0) begin
        chk("hold_data", 64'(fused_data), 64'(exp_q[0].data));
        chk("hold_err",  64'(err_ch),     64'(exp_q[0].err));
      end
      @(posedge clk);
      #1;
      sync_signal = 1'b0;
      if (poke && h == 0) chk("sync_drop_set", 64'(sync_drop), 64'd1);
      if (poke && h == 1) chk("sync_drop_pulse", 64'(sync_drop), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    if (poke) begin
      repeat (4) begin
        @(negedge clk);
        chk("no_new_frame_valid", 64'(out_valid), 64'd0);
        chk("no_new_frame_ready", 64'(ch_ready),  64'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mid_reset();
    bit seen;
    sync_signal = 1'b1;
    t_common    = 32'd1000;
    mode        = 1'b0;
    @(posedge clk);
    #1;
    sync_signal  = 1'b0;
    drv_valid[0] = 1'b1;
    drv_ts[0]    = 32'd950;
    drv_data[0]  = $urandom;
    @(posedge clk);
    #1;
    drv_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_reset_outs("mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("no_frame_after_reset", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handed-over frame must match the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=frame required=none ts=%0d", fused_ts);
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_data",  64'(fused_data), 64'(mon_e.data));
          chk("frame_ts",    64'(fused_ts),   64'(mon_e.ts));
          chk("frame_err",   64'(err_ch),     64'(mon_e.err));
          chk("frame_error", 64'(error),      64'(|mon_e.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint tgt;
    int     k;
    for (int c = 0; c < NCH; c++) begin
      drv_valid[c] = 1'b0; drv_ts[c] = '0; drv_data[c] = '0;
    end
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nearest: ch0 -> 1020, ch1 -> 990.
    clear_s(); add_s(0, 950); add_s(0, 1020); add_s(1, 990); add_s(1, 1100);
    run_frame(1000, 1'b0, 0, 1'b0, 0);
    // Carry-over, backpressure and a sync dropped during OUTPUT.
    clear_s(); add_s(0, 1080);
    run_frame(1050, 1'b0, 5, 1'b1, 0);
    // Zero-order hold.
    do_reset();
    clear_s(); add_s(0, 950); add_s(0, 1020); add_s(1, 990); add_s(1, 1100);
    run_frame(1000, 1'b1, 1, 1'b0, 0);
    // Tie picks PREV.
    do_reset();
    clear_s(); add_s(0, 980); add_s(0, 1020); add_s(1, 990); add_s(1, 1100);
    run_frame(1000, 1'b0, 0, 1'b0, 0);
    // Timeout with a silent ch1.
    do_reset();
    clear_s(); add_s(0, 950); add_s(0, 1020);
    run_frame(1000, 1'b0, 2, 1'b0, TO);
    // Skew error on ch0, data still emitted.
    do_reset();
    clear_s(); add_s(0, 1200); add_s(1, 990); add_s(1, 1010);
    run_frame(1000, 1'b0, 0, 1'b0, 0);
    // Out-of-order sample discarded; ch0 skew exactly at the limit.
    clear_s(); add_s(1, 1090); add_s(1, 1000); add_s(1, 1150);
    run_frame(1100, 1'b0, 0, 1'b0, 0);
    // Reset mid-COLLECT.
    mid_reset();

    tgt = 2000;
    repeat (40) begin
      tgt += $urandom_range(50, 400);
      clear_s();
      for (int c = 0; c < NCH; c++) begin
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) add_s(c, tgt - $urandom_range(0, 300));
        if ($urandom_range(0, 99) < 85) add_s(c, tgt + $urandom_range(1, 300));
      end
      run_frame(tgt, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 0);
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporal_aligner_n.md
TEMPORAL_ALIGNER_N -- requirements
Module: temporal_aligner_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sensor channels (1..16).
REQ-002 SHALL have parameter PAYLOAD_W, default 64, per-channel payload bits.
REQ-003 SHALL have parameter TS_W, default 64, unsigned timestamp bits; no wrap-around is handled.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum COLLECT cycles.
REQ-005 SHALL have parameter MAX_SKEW, default 1000, maximum allowed |chosen_ts - target| in timestamp units.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port sync_signal, input, 1 bit: single-cycle alignment request.
REQ-009 SHALL have port t_common, input, TS_W bits: common time, sampled as target on an accepted sync.
REQ-010 SHALL have port mode, input, 1 bit: 0 = nearest sample, 1 = previous sample (zero-order hold); sampled with the target.
REQ-011 SHALL have port ch_valid, input, NUM_CH bits: per-channel sample valid.
REQ-012 SHALL have port ch_ready, output, NUM_CH bits: per-channel sample accept.
REQ-013 SHALL have port ch_ts, input, NUM_CH*TS_W bits: sample timestamps; channel i at [i*TS_W +: TS_W].
REQ-014 SHALL have port ch_data, input, NUM_CH*PAYLOAD_W bits: sample payloads, packed the same way.
REQ-015 SHALL have port fused_data, output, NUM_CH*PAYLOAD_W bits: aligned payloads.
REQ-016 SHALL have port fused_ts, output, TS_W bits: target of the emitted frame.
REQ-017 SHALL have port out_valid, input-side out_ready: out_valid output 1 bit, out_ready input 1 bit; frame handshake.
REQ-018 SHALL have port err_ch, output, NUM_CH bits: per-channel error (timeout, missing prev, or skew) for the current frame.
REQ-019 SHALL have port error, output, 1 bit: OR of err_ch, qualified by out_valid.
REQ-020 SHALL have port sync_drop, output, 1 bit: one-cycle pulse when a sync is ignored.

Function
REQ-021 SHALL keep per channel a PREV slot (ts <= target) and a NEXT slot (ts > target), each with data, ts and a valid bit.
REQ-022 Top FSM SHALL have states IDLE, COLLECT and OUTPUT.
- IDLE -> COLLECT on sync_signal; target <= t_common; mode latched; timeout counter cleared.
REQ-023 On entering COLLECT, each channel SHALL be processed as follows.
- If NEXT is valid and NEXT.ts <= target: PREV <= NEXT and NEXT is invalidated.
- Otherwise, if NEXT is valid, the channel is immediately locked.
REQ-024 In COLLECT, ch_ready[i] SHALL be 1 only while channel i is unlocked; a sample transfers when ch_valid & ch_ready.
REQ-025 For an accepted sample, the channel SHALL act as follows.
- ts < PREV.ts (PREV valid): discard.
- ts <= target: PREV <= sample.
- ts > target: NEXT <= sample and channel locked.
REQ-026 COLLECT -> OUTPUT SHALL occur on the cycle after all channels are locked; out_valid SHALL assert on entry to OUTPUT.
REQ-027 COLLECT -> OUTPUT SHALL also occur when the counter reaches TIMEOUT-1; err_ch SHALL then flag the unlocked channels and their fused_data SHALL be zero.
REQ-028 Mode 0 selection SHALL choose PREV if PREV is valid and (target-PREV.ts) <= (NEXT.ts-target); otherwise NEXT. A tie SHALL select PREV.
REQ-029 Mode 1 selection SHALL choose PREV; if PREV is invalid, err_ch[i]=1 and the lane data SHALL be zero.
REQ-030 Skew SHALL be checked on the selected sample: if |chosen_ts - target| > MAX_SKEW, err_ch[i]=1 and the data is still emitted.
- Differences SHALL be computed in TS_W+1 bits and SHALL NOT overflow.
REQ-031 In OUTPUT, fused_data, fused_ts and err_ch SHALL be held stable while out_valid=1 and out_ready=0.
REQ-032 OUTPUT -> IDLE SHALL occur on out_valid & out_ready; out_valid SHALL deassert on the next cycle.
REQ-033 A sync_signal in COLLECT or OUTPUT SHALL be ignored and sync_drop pulsed the next cycle.
- A sync coinciding with the IDLE-entry cycle after handshake SHALL be ignored.
REQ-034 PREV and NEXT contents SHALL persist across frames; only reset clears them.
REQ-035 ch_ready SHALL be 0 in IDLE and OUTPUT.

Reset
REQ-036 While rst_n=0, all the following SHALL be 0 asynchronously: FSM=IDLE, all slot valid bits, ch_ready, out_valid, fused_data, fused_ts, err_ch, error, sync_drop, target and counter.
REQ-037 Reset asserted mid-COLLECT or mid-OUTPUT SHALL abort the frame with no output; operation SHALL resume from IDLE after release.

Verification (NUM_CH=2, TIMEOUT=16, MAX_SKEW=100)
REQ-038 Nearest scenario.
- Stimulus: sync with t_common=1000, mode 0; ch0 samples ts 950/1020; ch1 samples 990/1100.
- Required: out_valid with fused ch0=1020 data, ch1=990 data, err_ch=00, fused_ts=1000.
REQ-039 Hold and tie scenario.
- Stimulus: mode 1 with the same stimulus -> ch0=950 data, ch1=990 data.
- Stimulus: mode 0 with ch0 samples 980/1020 (tie) -> PREV (980) selected.
REQ-040 Timeout scenario.
- Stimulus: ch1 sends nothing.
- Required: out_valid on the 16th COLLECT cycle, err_ch=10, ch1 lane zero, error=1.
REQ-041 Carry-over and backpressure scenario.
- Stimulus: frame 2 sync with t_common=1050; ch0 NEXT=1020 moves to PREV; ch1 NEXT=1100 locks immediately. out_ready held low 5 cycles.
- Required: outputs stable; a sync during OUTPUT -> sync_drop=1, no new frame.
REQ-042 Skew, out-of-order and reset scenario.
- Stimulus: ch0 only sample ts 1200 vs target 1000 -> err_ch[0]=1, data emitted.
- Stimulus: ts below PREV.ts -> sample discarded.
- Stimulus: rst_n low mid-COLLECT -> all outputs 0 and no frame emitted.
